// File: rtl/serv_bufreg_wide_pkg.sv
// serv_bufreg_wide_pkg: access-size encodings and beat-count helper shared by the buffer register
package serv_bufreg_wide_pkg;
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    function automatic int beats(input int w);
        return 32 / w;
    endfunction
endpackage

// File: rtl/serv_bufreg_wide_funnel_shift.sv
// serv_funnel_shift: selects a W-bit window out of a 2W-bit {current, previous} beat pair
module serv_funnel_shift #(
    parameter int W = 1,
    parameter int LB = $clog2(W)
) (
    input  logic [2*W-1:0] win,
    input  logic [LB:0]    k,
    output logic [W-1:0]   q
);
    logic [2*W-1:0] sh;
    assign sh = win << k;
    assign q = sh[2*W-1:W];
endmodule

// File: rtl/serv_bufreg_wide.sv
// serv_bufreg_wide: 32-bit serial buffer register moving W bits per beat; accumulates rs1+imm
// on init passes and streams the register out through a funnel shifter otherwise.
module serv_bufreg_wide
    import serv_bufreg_wide_pkg::*;
#(
    parameter bit MDU = 1'b0,
    parameter int W = 1,
    parameter int LB = $clog2(W)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_init,
    input  logic          i_mdu_op,
    input  logic          i_rs1_en,
    input  logic          i_imm_en,
    input  logic          i_clr_lsb,
    input  logic          i_shift_op,
    input  logic          i_right_shift_op,
    input  logic          i_sh_signed,
    input  logic [1:0]    i_size,
    input  logic [W-1:0]  i_rs1,
    input  logic [W-1:0]  i_imm,
    input  logic [LB:0]   i_shamt_lsb,
    output logic [W-1:0]  o_q,
    output logic [1:0]    o_lsb,
    output logic          o_misalign,
    output logic          o_cnt0,
    output logic          o_last,
    output logic [31:0]   o_dbus_adr,
    output logic [31:0]   o_ext_rs1
);
    localparam int N = beats(W);
    localparam int CW = $clog2(N);

    if (W != 1 && W != 2 && W != 4 && W != 8) begin : g_bad_w
        $error("serv_bufreg_wide: W must be 1, 2, 4 or 8");
    end

    logic [31:0]   data;
    logic [W-1:0]  prev, prev_eff, rs1g, immg, fill, q;
    logic [W:0]    sum;
    logic          c_r, cnt0, last, lsb_cap;
    logic [1:0]    lsb, lsb_nxt;
    logic [CW-1:0] cnt;
    logic [LB:0]   k;

    assign cnt0 = cnt == '0;
    assign last = cnt == CW'(N - 1);

    always_comb begin
        rs1g = i_rs1_en ? i_rs1 : '0;
        immg = (i_imm_en ? i_imm : '0) & ~W'(i_clr_lsb & cnt0);
        sum = {1'b0, rs1g} + {1'b0, immg} + (W + 1)'(c_r);
        fill = i_sh_signed ? {W{data[31]}} : '0;
        prev_eff = cnt0 ? '0 : prev;
        k = !i_shift_op ? '0 : !i_right_shift_op ? i_shamt_lsb :
            i_shamt_lsb == '0 ? '0 : (LB + 1)'(W) - i_shamt_lsb;
        // with one bit per beat the two address LSBs arrive over the first two beats
        lsb_cap = i_en & i_init & (W == 1 ? cnt < CW'(2) : cnt0);
        lsb_nxt = W == 1 ? {sum[0], lsb[1]} : sum[1:0];
    end

    serv_funnel_shift #(.W(W), .LB(LB)) funnel (
        .win ({data[W-1:0], prev_eff}),
        .k   (k),
        .q   (q)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data <= '0;
            c_r  <= 1'b0;
            prev <= '0;
            lsb  <= '0;
            cnt  <= '0;
        end else if (i_en) begin
            data <= {i_init ? sum[W-1:0] : fill, data[31:W]};
            c_r  <= sum[W] & ~last;
            prev <= data[W-1:0];
            cnt  <= cnt + 1'b1;
            if (lsb_cap) lsb <= lsb_nxt;
        end
    end

    assign o_q        = i_en ? q : '0;
    assign o_lsb      = (MDU && i_mdu_op) ? 2'b00 : lsb;
    assign o_misalign = i_size == SIZE_H ? lsb[0] : i_size == SIZE_W ? |lsb : 1'b0;
    assign o_cnt0     = cnt0;
    assign o_last     = last;
    assign o_dbus_adr = {data[31:2], 2'b00};
    assign o_ext_rs1  = data;
endmodule

// File: tb/tb_serv_bufreg_wide.sv
// tb_serv_bufreg_wide: scoreboard bench running W = 1, 2, 4, 8 instances against a pass-level model
module tb_serv_bufreg_wide;
    typedef struct packed {
        logic [7:0]  q;
        logic        cnt0;
        logic        last;
        logic [1:0]  lsb;
        logic        mis;
        logic [31:0] ext;
    } exp_t;

    logic clk = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int w, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL W=%0d %s: got 0x%0h, expected 0x%0h", w, nm, act, req);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_w
        localparam int W = 1 << g;
        localparam int N = 32 / W;
        localparam int LB = $clog2(W);
        localparam bit MDU = (g % 2) == 1;

        logic rst_n = 1'b0, en = 1'b0, init = 1'b0, mdu_op = 1'b0;
        logic rs1_en = 1'b0, imm_en = 1'b0, clr_lsb = 1'b0;
        logic shift_op = 1'b0, right = 1'b0, sh_signed = 1'b0;
        logic [1:0] size = '0;
        logic [W-1:0] rs1 = '0, imm = '0, q;
        logic [LB:0] shamt = '0;
        logic [1:0] lsb;
        logic misalign, cnt0, last;
        logic [31:0] adr, ext;
        logic fin = 1'b0;
        logic [31:0] val = '0;
        logic [1:0] lsb_m = '0;
        exp_t sb[$];

        serv_bufreg_wide #(.MDU(MDU), .W(W)) dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_mdu_op(mdu_op),
            .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb), .i_shift_op(shift_op),
            .i_right_shift_op(right), .i_sh_signed(sh_signed), .i_size(size), .i_rs1(rs1),
            .i_imm(imm), .i_shamt_lsb(shamt), .o_q(q), .o_lsb(lsb), .o_misalign(misalign),
            .o_cnt0(cnt0), .o_last(last), .o_dbus_adr(adr), .o_ext_rs1(ext)
        );

        function automatic logic mis_of(input logic [1:0] l, input logic [1:0] sz);
            return sz == 2'b01 ? l[0] : sz == 2'b10 ? |l : 1'b0;
        endfunction

        function automatic int kval();
            return !shift_op ? 0 : !right ? int'(shamt) : shamt == 0 ? 0 : W - int'(shamt);
        endfunction

        // register contents after i beats: old value shifted down, new value entering at the top
        function automatic logic [31:0] data_at(input logic [31:0] old, input logic [31:0] nw, input int i);
            logic [63:0] t;
            t = ({32'h0, old} >> (i * W)) | ({32'h0, nw} << (32 - i * W));
            return t[31:0];
        endfunction

        task automatic push(input logic [W-1:0] qe, input int beat, input logic [31:0] exte);
            exp_t e;
            e = '0;
            e.q[W-1:0] = en ? qe : '0;
            e.cnt0 = beat == 0;
            e.last = beat == N - 1;
            e.lsb = (MDU && mdu_op) ? 2'b00 : lsb_m;
            e.mis = mis_of(lsb_m, size);
            e.ext = exte;
            sb.push_back(e);
            @(posedge clk);
            #1;
        endtask

        task automatic rnd_side();
            init = 1'($urandom);
            rs1 = W'($urandom);
            imm = W'($urandom);
            mdu_op = 1'($urandom);
            size = 2'($urandom);
        endtask

        task automatic idle(input int n);
            for (int j = 0; j < n; j++) begin
                en = 1'b0;
                rst_n = 1'b1;
                rnd_side();
                push('0, 0, val);
            end
        endtask

        task automatic pass(input logic ini, input logic [31:0] a, input logic [31:0] b,
                            input logic ae, input logic be, input logic cl, input logic sop,
                            input logic rt, input int s, input logic sgn, input int abort_at);
            logic [31:0] old, nw;
            logic [63:0] t;
            rs1_en = ae; imm_en = be; clr_lsb = cl;
            shift_op = sop; right = rt; sh_signed = sgn;
            shamt = (LB + 1)'(s % W);
            old = val;
            nw = ini ? (ae ? a : 32'h0) + ((be ? b : 32'h0) & ~{31'h0, cl})
                     : (sgn && old[31]) ? 32'hFFFF_FFFF : 32'h0;
            for (int i = 0; i < N; i++) begin
                while ($urandom_range(4) == 0) begin
                    en = 1'b0;
                    rnd_side();
                    push('0, i, data_at(old, nw, i));
                end
                rnd_side();
                en = 1'b1;
                init = ini;
                rs1 = a[i*W +: W];
                imm = b[i*W +: W];
                rst_n = (i != abort_at);
                t = {32'h0, old} << kval();
                push(W'(t >> (i * W)), i, data_at(old, nw, i));
                if (i == abort_at) begin
                    rst_n = 1'b1;
                    val = '0;
                    lsb_m = '0;
                    return;
                end
                if (ini && W == 1 && i < 2) lsb_m = {nw[i], lsb_m[1]};
                else if (ini && W != 1 && i == 0) lsb_m = nw[1:0];
            end
            val = nw;
        endtask

        initial begin
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            push('0, 0, 32'h0);
            size = 2'b10;
            push('0, 0, 32'h0);
            pass(1, 32'h0000_1003, 32'h1, 1, 1, 0, 0, 0, 0, 0, -1);
            idle(4);
            pass(1, 32'hFFFF_FFFF, 32'h1, 1, 1, 0, 0, 0, 0, 0, -1);
            pass(1, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 0, -1);
            pass(1, 32'h101, 32'h0, 1, 1, 1, 0, 0, 0, 0, -1);
            idle(2);
            pass(1, 32'h101, 32'h0, 1, 1, 0, 0, 0, 0, 0, -1);
            for (int j = 0; j < 8; j++) begin
                en = 1'b0;
                size = 2'(j);
                mdu_op = 1'(j >> 2);
                push('0, 0, val);
            end
            pass(1, 32'h8000_0000, 32'h0, 1, 1, 0, 0, 0, 0, 0, -1);
            pass(0, $urandom, $urandom, 1, 1, 0, 0, 0, 0, 1, -1);
            pass(1, 32'h8000_0000, 32'h0, 1, 1, 0, 0, 0, 0, 0, -1);
            pass(0, $urandom, $urandom, 1, 1, 0, 0, 0, 0, 0, -1);
            pass(1, 32'h0000_000F, 32'h0, 1, 1, 0, 0, 0, 0, 0, -1);
            pass(0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 1, 0, -1);
            pass(1, 32'h1234_5677, 32'h0, 1, 1, 0, 0, 0, 0, 0, -1);
            pass(1, $urandom, $urandom, 1, 1, 0, 0, 0, 0, 0, N > 5 ? 5 : N - 1);
            idle(3);
            for (int j = 0; j < 18; j++)
                pass(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), $urandom_range(W - 1), 1'($urandom), -1);
            idle(2);
            fin = 1'b1;
        end

        always @(negedge clk) begin
            exp_t e;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("o_q", W, 32'(q), 32'(e.q[W-1:0]));
                chk("o_cnt0", W, 32'(cnt0), 32'(e.cnt0));
                chk("o_last", W, 32'(last), 32'(e.last));
                chk("o_lsb", W, 32'(lsb), 32'(e.lsb));
                chk("o_misalign", W, 32'(misalign), 32'(e.mis));
                chk("o_ext_rs1", W, ext, e.ext);
                chk("o_dbus_adr", W, adr, {e.ext[31:2], 2'b00});
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_w[0].fin && g_w[1].fin && g_w[2].fin && g_w[3].fin) && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 60000) begin
            miscompares++;
            $display("FAIL timeout: stimulus finished 0, expected 1 within 60000 cycles");
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
